wall_spawner: RTL
=================

Name: wall_spawner

Overview:
Sequential wall-placement engine for WALL_SPAWN mode. It sits upstream of the wall collision/render path and owns the 25-entry wall list that wall collision consumes. On each spawn request it takes a candidate location from the wall-mode random generator, then checks it serially against the border, the apple, every live snake segment and every existing wall. A clean candidate is committed to the list; a rejected one triggers a retry.

Parameters:
MAX_LENGTH, 30, number of snake segment slots in snakeArrayX/Y
MAX_WALLS, 25, wall list depth
MAX_TRIES, 16, candidate attempts per request before giving up

Ports:
system_clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous new-game clear of the wall list
spawn_req  input  1  one-cycle request (good_collision while in WALL_SPAWN)
rand_xy  input  8  candidate {x[7:4], y[3:0]} from wall-mode random generator
rand_advance  output  1  one-cycle pulse asking the generator for its next value
apple_xy  input  8  current apple {x,y}
snake_length  input  5  live segments, 0..MAX_LENGTH; index 0 is the head
snakeArrayX, snakeArrayY  input  MAX_LENGTH x 4  packed segment coordinates
xmax, xmin, ymax, ymin  input  4 each  current border; the border cells themselves are wall
wall_locations  output  MAX_WALLS x 8  wall list; unused slots read 8'h00
wall_count  output  5  valid entries, 0..MAX_WALLS
busy  output  1  high in every state except IDLE
spawn_done  output  1  one-cycle completion pulse
spawn_ok  output  1  qualifies spawn_done: 1 = committed, 0 = full or attempts exhausted

Behaviour:
- Reset (async, active-high): all wall_locations = 8'h00, wall_count = 0, state IDLE, attempt counter 0. rand_advance, spawn_done, spawn_ok and busy are all 0.
- clear (synchronous): same effect as reset. It takes priority over every state, so a scan in progress is aborted with no spawn_done.
- States: IDLE, CHECK, SCAN_SNAKE, SCAN_WALL, COMMIT, RETRY, LOAD.
- IDLE:
  - spawn_req with wall_count == MAX_WALLS: next cycle pulse spawn_done = 1 with spawn_ok = 0; stay in IDLE.
  - Otherwise: latch cand <= rand_xy, attempts <= 1, go to CHECK.
  - spawn_req outside IDLE is ignored, never queued.
- CHECK (1 cycle): reject if any of these hold: x <= xmin, x >= xmax, y <= ymin, y >= ymax, or cand == apple_xy.
  - Reject: go to RETRY.
  - Pass, snake_length > 0: idx <= 0, go to SCAN_SNAKE.
  - Pass, snake_length == 0: go to SCAN_WALL (or COMMIT if wall_count == 0).
- SCAN_SNAKE: one segment per cycle, comparing cand against {snakeArrayX[idx], snakeArrayY[idx]}.
  - Match: go to RETRY.
  - No match at idx == snake_length-1: idx <= 0, go to SCAN_WALL, or to COMMIT if wall_count == 0.
  - Snake inputs are sampled live each cycle; upstream holds them stable while busy.
- SCAN_WALL: one entry per cycle, comparing cand against wall_locations[idx] for idx < wall_count.
  - Match: go to RETRY.
  - No match at the last entry: go to COMMIT.
- COMMIT:
  - At the exit edge: wall_locations[wall_count] <= cand and wall_count += 1.
  - spawn_done = 1 and spawn_ok = 1 are registered at that same edge, so the pulse coincides with the updated list.
  - Return to IDLE.
- RETRY:
  - attempts == MAX_TRIES: registered spawn_done = 1, spawn_ok = 0, go to IDLE; the list is unchanged.
  - Otherwise: rand_advance = 1 for this cycle, go to LOAD.
- LOAD: cand <= rand_xy (the advanced value), attempts += 1, go to CHECK.
- Latency: request sampled in cycle 0, first candidate clean, L = snake_length, W = wall_count. spawn_done and the updated wall_locations/wall_count appear in cycle 3+L+W. Each retry adds 2 cycles plus the rescan.
- Width rules: idx and wall_count are 5 bits. Comparisons are unsigned 4-bit per axis. Empty slots stay 8'h00, which is always a border cell, so 8'h00 is never a valid wall.
- Reset mid-scan: immediate return to the reset state; no partial commit.

Test Plan:
- Border 0/15, snake_length 3 at (5,5),(4,5),(3,5), apple 8'h99, empty list, rand_xy = 8'h77, spawn_req -> spawn_done, spawn_ok = 1 in cycle 6; wall_locations[0] = 8'h77, wall_count = 1, rand_advance never high.
- Same setup, rand_xy = 8'h55 then 8'hA3 after advance -> one rand_advance pulse, then commit of 8'hA3, wall_count = 1.
- Candidate 8'h0F (on the border) held constant -> 16 attempts, then spawn_done with spawn_ok = 0; wall_count unchanged.
- Fill to 25 walls, then spawn_req -> spawn_done with spawn_ok = 0 one cycle later; busy stays 0; list unchanged.
- Existing wall 8'h77, candidate 8'h77 then 8'h78 -> first rejected in SCAN_WALL, 8'h78 stored at index 1.
- Assert clear, then separately reset, mid-SCAN_SNAKE -> wall_count = 0, all slots 8'h00, no spawn_done, busy = 0 next cycle.

Source files
------------

// File: rtl/wall_spawner.sv
// Sequential wall placement engine: checks random candidates against the
// border, the apple, each live snake segment and each stored wall, then
// commits a clean one to the wall list.
// Ports: system_clk/reset/clear control; spawn_req starts a placement;
// rand_xy/rand_advance talk to the wall-mode random generator; apple_xy,
// snake_length, snakeArrayX/Y and x/y min/max are the occupancy inputs;
// wall_locations/wall_count expose the list; busy, spawn_done and spawn_ok
// report progress and result.
module wall_spawner #(
  parameter int MAX_LENGTH = 30,
  parameter int MAX_WALLS  = 25,
  parameter int MAX_TRIES  = 16
) (
  input  logic                          system_clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          spawn_req,
  input  logic [7:0]                    rand_xy,
  output logic                          rand_advance,
  input  logic [7:0]                    apple_xy,
  input  logic [4:0]                    snake_length,
  input  logic [MAX_LENGTH-1:0][3:0]    snakeArrayX,
  input  logic [MAX_LENGTH-1:0][3:0]    snakeArrayY,
  input  logic [3:0]                    xmax,
  input  logic [3:0]                    xmin,
  input  logic [3:0]                    ymax,
  input  logic [3:0]                    ymin,
  output logic [MAX_WALLS-1:0][7:0]     wall_locations,
  output logic [4:0]                    wall_count,
  output logic                          busy,
  output logic                          spawn_done,
  output logic                          spawn_ok
);

  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam logic [AW-1:0] TRIES_L = AW'(MAX_TRIES);
  localparam logic [4:0]    WALLS_L = 5'(MAX_WALLS);

  typedef enum logic [2:0] {
    IDLE, CHECK, SCAN_SNAKE, SCAN_WALL, COMMIT, RETRY, LOAD
  } state_t;

  state_t                      state_q;
  logic [7:0]                  cand_q;
  logic [4:0]                  idx_q;
  logic [AW-1:0]               attempts_q;
  logic [MAX_WALLS-1:0][7:0]   walls_q;
  logic [4:0]                  wcnt_q;
  logic                        adv_q;
  logic                        done_q;
  logic                        ok_q;

  logic [3:0] cand_x;
  logic [3:0] cand_y;
  logic       border_hit;
  logic       apple_hit;
  logic       snake_hit;
  logic       wall_hit;
  logic       last_seg;
  logic       last_wall;
  logic       may_retry;

  assign cand_x = cand_q[7:4];
  assign cand_y = cand_q[3:0];

  // Border cells are walls themselves, so touching the border is a reject.
  assign border_hit = (cand_x <= xmin) || (cand_x >= xmax) ||
                      (cand_y <= ymin) || (cand_y >= ymax);
  assign apple_hit  = (cand_q == apple_xy);
  assign snake_hit  = (cand_q == {snakeArrayX[idx_q], snakeArrayY[idx_q]});
  assign wall_hit   = (cand_q == walls_q[idx_q]);
  assign last_seg   = (idx_q == snake_length - 5'd1);
  assign last_wall  = (idx_q == wcnt_q - 5'd1);
  assign may_retry  = (attempts_q != TRIES_L);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= 8'h00;
      idx_q      <= 5'd0;
      attempts_q <= '0;
      walls_q    <= '0;
      wcnt_q     <= 5'd0;
      adv_q      <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else if (clear) begin
      // New game: wipe the list and abandon any placement in flight.
      state_q    <= IDLE;
      cand_q     <= 8'h00;
      idx_q      <= 5'd0;
      attempts_q <= '0;
      walls_q    <= '0;
      wcnt_q     <= 5'd0;
      adv_q      <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      adv_q  <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spawn_req) begin
            if (wcnt_q == WALLS_L) begin
              done_q <= 1'b1;
            end else begin
              cand_q     <= rand_xy;
              attempts_q <= AW'(1);
              state_q    <= CHECK;
            end
          end
        end
        CHECK: begin
          idx_q <= 5'd0;
          if (border_hit || apple_hit) begin
            // rand_advance is raised for the whole RETRY cycle when another try remains.
            adv_q   <= may_retry;
            state_q <= RETRY;
          end else if (snake_length != 5'd0) begin
            state_q <= SCAN_SNAKE;
          end else begin
            state_q <= (wcnt_q == 5'd0) ? COMMIT : SCAN_WALL;
          end
        end
        SCAN_SNAKE: begin
          if (snake_hit) begin
            adv_q   <= may_retry;
            state_q <= RETRY;
          end else if (last_seg) begin
            idx_q   <= 5'd0;
            state_q <= (wcnt_q == 5'd0) ? COMMIT : SCAN_WALL;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        SCAN_WALL: begin
          if (wall_hit) begin
            adv_q   <= may_retry;
            state_q <= RETRY;
          end else if (last_wall) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        COMMIT: begin
          // Done pulse lands on the same edge as the list update.
          walls_q[wcnt_q] <= cand_q;
          wcnt_q          <= wcnt_q + 5'd1;
          done_q          <= 1'b1;
          ok_q            <= 1'b1;
          state_q         <= IDLE;
        end
        RETRY: begin
          if (!may_retry) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Generator advanced at the end of RETRY, so rand_xy is fresh here.
          cand_q     <= rand_xy;
          attempts_q <= attempts_q + AW'(1);
          state_q    <= CHECK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rand_advance   = adv_q;
  assign spawn_done     = done_q;
  assign spawn_ok       = ok_q;
  assign wall_locations = walls_q;
  assign wall_count     = wcnt_q;
  assign busy           = (state_q != IDLE);

endmodule
